// File: rtl/sensor_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sensor_stream_arbiter_if
// Description : Bundles the sensor-channel handshakes and the frame output
//               handshake of sensor_stream_arbiter. The master modport is
//               the arbiter; the slave modport is the surrounding system
//               (sensor sources plus UART controller).
// Revision    : 1.0 - initial release
// ============================================================================
interface sensor_stream_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 24,
    parameter int TX_W   = 56
);
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_ack;
    logic [NUM_CH-1:0]        ch_enable;
    logic [TX_W-1:0]          tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic                     busy;

    modport master (
        input  ch_data, ch_valid, ch_enable, tx_ready,
        output ch_ack, tx_data, tx_valid, busy
    );

    modport slave (
        output ch_data, ch_valid, ch_enable, tx_ready,
        input  ch_ack, tx_data, tx_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/sensor_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sensor_stream_arbiter
// Description : Round-robin arbiter over NUM_CH level-valid/pulse-ack sensor
//               streams. Each granted sample is packed into a TX_W-bit frame
//               {SYNC_BYTE, id, seq, sample} and offered on a valid/ready
//               handshake. Optional macro STREAM_ARB_PRIORITY_EN gives
//               channel 0 absolute priority without moving the pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_stream_arbiter #(
    parameter int         NUM_CH    = 4,
    parameter int         DATA_W    = 24,
    parameter int         TX_W      = 56,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sensor_stream_arbiter_if.master bus
);
    localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW    = ID_W + 1;
    localparam int PAY_W = TX_W - 24;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GRANT    = 2'd1,
        S_SEND     = 2'd2,
        S_WAIT_LOW = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [7:0]          r_seq [NUM_CH];
    logic [TX_W-1:0]     r_tx_data;
    logic [NUM_CH-1:0]   w_req;
    logic [NUM_CH-1:0]   w_ack;
    logic [ID_W-1:0]     w_gnt_id;
    logic                w_found;
    logic                w_upd_ptr;
    logic [CW-1:0]       w_cand;
    logic [DATA_W-1:0]   w_sample;
    logic [TX_W-1:0]     w_frame;
    logic                w_handshake;

    assign w_req       = bus.ch_valid & bus.ch_enable;
    assign w_handshake = (r_state == S_SEND) && bus.tx_ready;

    // Pick the first requester after the pointer, wrapping; channel 0 may pre-empt.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_id  = '0;
        w_upd_ptr = 1'b0;
        w_cand    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_cand = {1'b0, r_ptr} + CW'(i);
            if (w_cand >= CW'(NUM_CH)) begin
                w_cand = w_cand - CW'(NUM_CH);
            end
            if (!w_found && w_req[w_cand[ID_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_id  = w_cand[ID_W-1:0];
                w_upd_ptr = 1'b1;
            end
        end
`ifdef STREAM_ARB_PRIORITY_EN
        // Channel 0 wins outright and leaves the rotation of the others alone.
        if (w_req[0]) begin
            w_found   = 1'b1;
            w_gnt_id  = '0;
            w_upd_ptr = 1'b0;
        end
`endif
    end

    // Frame assembly from the currently selected channel.
    always_comb begin
        w_sample = bus.ch_data[int'(w_gnt_id)*DATA_W +: DATA_W];
        w_frame  = {SYNC_BYTE, 8'(w_gnt_id), r_seq[w_gnt_id], PAY_W'(w_sample)};
    end

    // Next-state and ack decode; ack is suppressed while reset is asserted.
    always_comb begin
        w_next = r_state;
        w_ack  = '0;
        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_next = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_found) begin
                    w_next = S_SEND;
                    if (rst_n) begin
                        w_ack[w_gnt_id] = 1'b1;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_SEND: begin
                if (w_handshake) begin
                    w_next = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant capture, pointer update and per-channel sequence counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr     <= ID_W'(NUM_CH - 1);
            r_id      <= '0;
            r_tx_data <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_seq[k] <= 8'd0;
            end
        end else begin
            if ((r_state == S_GRANT) && w_found) begin
                r_id      <= w_gnt_id;
                r_tx_data <= w_frame;
                if (w_upd_ptr) begin
                    r_ptr <= w_gnt_id;
                end
            end
            if (w_handshake) begin
                r_seq[r_id] <= r_seq[r_id] + 8'd1;
            end
        end
    end

    assign bus.ch_ack   = w_ack;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = (r_state == S_SEND);
    assign bus.busy     = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_sensor_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_stream_arbiter
// Description : Directed self-checking bench for sensor_stream_arbiter with
//               NUM_CH=4, DATA_W=24, TX_W=56. Sources drop valid one cycle
//               after their ack unless listed in keep_mask.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_stream_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sensor_stream_arbiter_if #(.NUM_CH(4), .DATA_W(24), .TX_W(56)) bus ();

    sensor_stream_arbiter #(
        .NUM_CH(4), .DATA_W(24), .TX_W(56), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc;
    int          ack_multi;
    int          ack_q [$];
    int          ack_cyc [$];
    logic [55:0] frame_q [$];
    int          frame_cyc [$];
    logic [3:0]  keep_mask;
    logic [3:0]  ack_prev;
    logic [23:0] dat [4] = '{24'h0A0A0A, 24'h111111, 24'h123456, 24'h333333};

    // Passive monitor: logs acks and completed frames on the falling edge.
    initial begin
        cyc = 0;
        ack_multi = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if ($countones(bus.ch_ack) > 1) ack_multi++;
                for (int k = 0; k < 4; k++) begin
                    if (bus.ch_ack[k]) begin
                        ack_q.push_back(k);
                        ack_cyc.push_back(cyc);
                    end
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    frame_q.push_back(bus.tx_data);
                    frame_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        ack_prev = bus.ch_ack;
        @(posedge clk);
        #1;
        bus.ch_valid = bus.ch_valid & ~(ack_prev & ~keep_mask);
    endtask

    task automatic clear_logs();
        ack_q.delete();
        ack_cyc.delete();
        frame_q.delete();
        frame_cyc.delete();
        ack_multi = 0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.ch_valid  = '0;
        bus.ch_enable = 4'hF;
        bus.tx_ready  = 1'b1;
        bus.ch_data   = {dat[3], dat[2], dat[1], dat[0]};
        keep_mask     = '0;
        step();
        step();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.ch_valid  = 4'hF;
        bus.ch_enable = 4'hF;
        bus.tx_ready  = 1'b1;
        bus.ch_data   = {dat[3], dat[2], dat[1], dat[0]};
        keep_mask     = 4'hF;
        step();
        step();
        n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
        n_checks++; if (bus.tx_data !== 56'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h want 0", bus.tx_data); end
        n_checks++; if (bus.ch_ack !== 4'h0) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", bus.ch_ack); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single();
        int req_c;
        do_reset();
        bus.ch_valid = 4'b0100;
        req_c = cyc + 1;
        repeat (6) step();
        n_checks++; if (ack_q.size() !== 1) begin n_fail++; $display("FAIL single_ack_count: got %0d want 1", ack_q.size()); end
        n_checks++; if (frame_q.size() !== 1) begin n_fail++; $display("FAIL single_frame_count: got %0d want 1", frame_q.size()); end
        if (ack_q.size() >= 1 && frame_q.size() >= 1) begin
            n_checks++; if (ack_q[0] !== 2) begin n_fail++; $display("FAIL single_ack_ch: got %0d want 2", ack_q[0]); end
            n_checks++; if (ack_cyc[0] - req_c !== 1) begin n_fail++; $display("FAIL single_ack_latency: got %0d want 1", ack_cyc[0] - req_c); end
            n_checks++; if (frame_q[0] !== 56'hA5_02_00_00123456) begin n_fail++; $display("FAIL single_frame: got %h want a502000012345 6", frame_q[0]); end
            n_checks++; if (frame_cyc[0] - req_c !== 2) begin n_fail++; $display("FAIL single_valid_latency: got %0d want 2", frame_cyc[0] - req_c); end
        end
        bus.ch_valid = 4'b0100;
        repeat (6) step();
        n_checks++; if (frame_q.size() !== 2) begin n_fail++; $display("FAIL single_second_count: got %0d want 2", frame_q.size()); end
        if (frame_q.size() >= 2) begin
            n_checks++; if (frame_q[1] !== 56'hA5_02_01_00123456) begin n_fail++; $display("FAIL single_second_seq: got %h want a5020100123456", frame_q[1]); end
        end
    endtask

    task automatic test_round_robin();
        logic [55:0] exp;
        do_reset();
        keep_mask    = 4'hF;
        bus.ch_valid = 4'hF;
        repeat (34) step();
        n_checks++; if (frame_q.size() < 8 || ack_q.size() < 8) begin n_fail++; $display("FAIL rr_count: got %0d frames want >=8", frame_q.size()); end
        if (frame_q.size() >= 8 && ack_q.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                exp = {8'hA5, 8'(i % 4), 8'(i / 4), 8'h00, dat[i % 4]};
                n_checks++; if (ack_q[i] !== i % 4) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, ack_q[i], i % 4); end
                n_checks++; if (frame_q[i] !== exp) begin n_fail++; $display("FAIL rr_frame[%0d]: got %h want %h", i, frame_q[i], exp); end
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (ack_cyc[i+1] - ack_cyc[i] !== 4) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want 4", i, ack_cyc[i+1] - ack_cyc[i]); end
            end
        end
        n_checks++; if (ack_multi !== 0) begin n_fail++; $display("FAIL rr_ack_onehot: got %0d multi-bit acks want 0", ack_multi); end
    endtask

    task automatic test_backpressure();
        logic [55:0] exp;
        int          t;
        exp = 56'hA5_01_00_00111111;
        do_reset();
        bus.tx_ready = 1'b0;
        bus.ch_valid = 4'b0010;
        t = 0;
        while (!bus.tx_valid && t < 10) begin step(); t++; end
        n_checks++; if (bus.tx_valid !== 1'b1) begin n_fail++; $display("FAIL bp_wait_valid: got %b want 1", bus.tx_valid); end
        keep_mask    = 4'b1000;
        bus.ch_valid = bus.ch_valid | 4'b1000;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (bus.tx_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held[%0d]: got %b want 1", i, bus.tx_valid); end
            n_checks++; if (bus.tx_data !== exp) begin n_fail++; $display("FAIL bp_data_stable[%0d]: got %h want %h", i, bus.tx_data, exp); end
            step();
        end
        n_checks++; if (ack_q.size() !== 1) begin n_fail++; $display("FAIL bp_no_extra_ack: got %0d want 1", ack_q.size()); end
        bus.tx_ready = 1'b1;
        step();
        n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", bus.tx_valid); end
        n_checks++; if (frame_q.size() !== 1) begin n_fail++; $display("FAIL bp_frame_count: got %0d want 1", frame_q.size()); end
        if (frame_q.size() >= 1) begin
            n_checks++; if (frame_q[0] !== exp) begin n_fail++; $display("FAIL bp_frame: got %h want %h", frame_q[0], exp); end
        end
    endtask

    task automatic test_mask();
        int exp_order [6] = '{0, 1, 3, 0, 1, 3};
        int n2;
        int t;
        do_reset();
        bus.ch_enable = 4'b1011;
        keep_mask     = 4'hF;
        bus.ch_valid  = 4'hF;
        repeat (26) step();
        n_checks++; if (ack_q.size() < 6) begin n_fail++; $display("FAIL mask_count: got %0d want >=6", ack_q.size()); end
        if (ack_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                n_checks++; if (ack_q[i] !== exp_order[i]) begin n_fail++; $display("FAIL mask_order[%0d]: got %0d want %0d", i, ack_q[i], exp_order[i]); end
            end
        end
        n2 = 0;
        foreach (ack_q[i]) if (ack_q[i] == 2) n2++;
        n_checks++; if (n2 !== 0) begin n_fail++; $display("FAIL mask_ch2_acked: got %0d acks want 0", n2); end
        t = 0;
        ack_prev = '0;
        while (ack_prev !== 4'b0010 && t < 20) begin step(); t++; end
        n_checks++; if (ack_prev !== 4'b0010) begin n_fail++; $display("FAIL mask_find_ch1: got %b want 0010", ack_prev); end
        bus.ch_enable = 4'hF;
        clear_logs();
        repeat (6) step();
        n_checks++; if (ack_q.size() < 1 || ack_q[0] !== 2) begin n_fail++; $display("FAIL mask_enable_ch2: got %0d acks first %0d want first 2", ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : -1); end
    endtask

    task automatic test_seq_wrap();
        logic [55:0] f;
        do_reset();
        keep_mask    = 4'b0010;
        bus.ch_valid = 4'b0010;
        repeat (1040) step();
        n_checks++; if (frame_q.size() < 257) begin n_fail++; $display("FAIL wrap_count: got %0d want >=257", frame_q.size()); end
        if (frame_q.size() >= 257) begin
            f = frame_q[254];
            n_checks++; if (f !== 56'hA5_01_FE_00111111) begin n_fail++; $display("FAIL wrap_fe: got %h want a501fe00111111", f); end
            f = frame_q[255];
            n_checks++; if (f !== 56'hA5_01_FF_00111111) begin n_fail++; $display("FAIL wrap_ff: got %h want a501ff00111111", f); end
            f = frame_q[256];
            n_checks++; if (f !== 56'hA5_01_00_00111111) begin n_fail++; $display("FAIL wrap_00: got %h want a5010000111111", f); end
        end
    endtask

    task automatic test_reset_midop();
        int t;
        do_reset();
        keep_mask    = 4'b0010;
        bus.ch_valid = 4'b0010;
        repeat (10) step();
        bus.tx_ready = 1'b0;
        t = 0;
        while (!bus.tx_valid && t < 10) begin step(); t++; end
        n_checks++; if (bus.tx_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_reach_send: got %b want 1", bus.tx_valid); end
        keep_mask    = 4'b1010;
        bus.ch_valid = 4'b1010;
        rst_n        = 1'b0;
        step();
        n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", bus.tx_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.tx_data !== 56'h0) begin n_fail++; $display("FAIL rmid_data: got %h want 0", bus.tx_data); end
        rst_n        = 1'b1;
        bus.tx_ready = 1'b1;
        clear_logs();
        repeat (8) step();
        n_checks++; if (ack_q.size() < 1 || ack_q[0] !== 1) begin n_fail++; $display("FAIL rmid_ptr_cleared: got first ack %0d want 1", (ack_q.size() > 0) ? ack_q[0] : -1); end
        n_checks++; if (frame_q.size() < 1 || frame_q[0] !== 56'hA5_01_00_00111111) begin n_fail++; $display("FAIL rmid_seq_cleared: got %h want a5010000111111", (frame_q.size() > 0) ? frame_q[0] : 56'h0); end
    endtask

    task automatic test_priority();
        int exp;
        do_reset();
        keep_mask    = 4'b1001;
        bus.ch_valid = 4'b1001;
        repeat (26) step();
        n_checks++; if (ack_q.size() < 6) begin n_fail++; $display("FAIL prio_count: got %0d want >=6", ack_q.size()); end
        if (ack_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
`ifdef STREAM_ARB_PRIORITY_EN
                exp = 0;
`else
                exp = (i % 2 == 0) ? 0 : 3;
`endif
                n_checks++; if (ack_q[i] !== exp) begin n_fail++; $display("FAIL prio_order[%0d]: got %0d want %0d", i, ack_q[i], exp); end
            end
        end
    endtask

    initial begin
        keep_mask = '0;
        ack_prev  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mask();
        test_seq_wrap();
        test_reset_midop();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sensor_stream_arbiter.md
Name: sensor_stream_arbiter

Overview:
- Generalised successor to the fixed single-path sensor-data routing in the sensor top level.
- Accepts NUM_CH sensor sample streams, each with a level-valid / pulse-ack handshake of the ADS1292 filtered-data kind.
- Arbitrates round-robin among enabled channels and packs each sample into a tagged, sequence-numbered TX_W-bit frame.
- Frames go to the UART controller over a valid/ready handshake.

Parameters:
- NUM_CH, 4: number of sensor input channels (1..16).
- DATA_W, 24: sample width per channel (1..TX_W-24).
- TX_W, 56: output frame width, matching the UART controller TX data width.
- SYNC_BYTE, 8'hA5: frame header byte.

Ports:
- i_CLK  input  1  system clock.
- i_RSTN  input  1  synchronous active-low reset.
- i_CH_DATA  input  NUM_CH*DATA_W  channel samples; channel k occupies bits [k*DATA_W +: DATA_W].
- i_CH_VALID  input  NUM_CH  per-channel level valid; held until acked.
- o_CH_ACK  output  NUM_CH  one-cycle ack pulse per channel.
- i_CH_ENABLE  input  NUM_CH  channel mask; 0 = channel ignored.
- o_TX_DATA  output  TX_W  packed frame.
- o_TX_VALID  output  1  frame valid.
- i_TX_READY  input  1  UART ready for the next frame.
- o_BUSY  output  1  high in any state except IDLE.

Behaviour:
- Reset state (i_RSTN low at a clock edge): all of the following are cleared.
  - o_CH_ACK=0, o_TX_DATA=0, o_TX_VALID=0, o_BUSY=0.
  - Round-robin pointer=NUM_CH-1, so channel 0 is checked first.
  - All per-channel sequence counters=0.
  - FSM=IDLE.
- Reset mid-operation: same reset state. The pending frame is discarded and no ack is issued.
- Request vector: req = i_CH_VALID & i_CH_ENABLE.
- IDLE: if req≠0, go to GRANT.
- GRANT:
  - Select the first set req bit scanning from pointer+1 upward, wrapping modulo NUM_CH.
  - Latch channel id, sample, and that channel's sequence value.
  - Pulse o_CH_ACK[id] for exactly this cycle.
  - Pointer ← id; go to SEND.
  - If req dropped to 0 in this cycle (mask changed), return to IDLE with no ack.
- SEND:
  - Assert o_TX_VALID with the registered o_TX_DATA.
  - Frame = {SYNC_BYTE[7:0], 4'b0 and id in low bits [7:0], seq[7:0], sample zero-extended to TX_W-24 bits}.
  - On a cycle with o_TX_VALID & i_TX_READY: increment seq[id] (8-bit, wraps 255→0), drop o_TX_VALID next cycle, go to WAIT_LOW.
  - o_TX_DATA stays stable while valid and not ready.
- WAIT_LOW:
  - One cycle, so the acked source can deassert valid (the ack-to-valid-drop latency of the source is 1 cycle).
  - Then go to IDLE.
- Latency: request seen in IDLE → ack 1 cycle later → o_TX_VALID 2 cycles after the request is first seen.
- Throughput: one frame per 4 cycles minimum when i_TX_READY is held high.
- Simultaneous requests are served in round-robin order; no channel waits more than NUM_CH-1 frames.
- A channel disabled while its request is pending is not acked and its sample stays in the source.
- Enabling a channel has effect at the next GRANT evaluation.
- NUM_CH=1: the pointer is a constant 0 and arbitration is trivial.
- o_CH_ACK is never high for more than one bit or more than one cycle per frame.

Optional Feature:
- STREAM_ARB_PRIORITY_EN defined:
  - Channel 0, when requesting and enabled, always wins GRANT regardless of the pointer.
  - The pointer is not updated when channel 0 wins.
  - Other channels keep round-robin among themselves.
- Undefined: pure round-robin as above.

Test Plan:
- Single request: NUM_CH=4, ch2 valid with data 24'h123456, i_TX_READY=1 → one ack on bit 2, then frame 56'hA5_02_00_00123456; the next ch2 frame carries seq 01.
- All four channels valid continuously, enable=4'hF → grant order 0,1,2,3,0,…; each channel's seq increments independently; ack spacing 4 cycles.
- Backpressure: i_TX_READY held low 10 cycles during SEND → o_TX_DATA constant, o_TX_VALID high throughout, no further acks; frame completes on the first ready cycle.
- Mask: enable=4'b1011 with all valid → ch2 is never acked; ch2 is served immediately after its enable is raised.
- Seq wrap and reset: 256 frames on ch1 → seq goes FF then 00. Reset asserted during SEND → o_TX_VALID=0 next cycle; seq and pointer are cleared.
- With STREAM_ARB_PRIORITY_EN, ch0 and ch3 always valid → every grant goes to ch0 and ch3 is starved; without the macro they alternate 0,3,0,3.
